// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the core LSU (port 0) and
// the DMA/loader (port 1). The bus side is combinational. Load data and error
// responses come back registered, one cycle after the grant.
module dmem_arbiter #(
    parameter bit FIXED_PRIO = 1'b0,
    parameter bit PRIO_RST   = 1'b0
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_size,
    input  logic        m0_uns,
    input  logic        m0_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_size,
    input  logic        m1_uns,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic        mem_we,
    output logic [3:0]  mem_amp,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam int unsigned DW = 32;
    localparam int unsigned BW = 8;
    localparam int unsigned HW = 16;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            prio_q, prio_d;

    logic            req0_ok, req1_ok;
    logic            gnt0_c, gnt1_c, gnt_any;

    logic            sel_we;
    logic [1:0]      sel_size;
    logic            sel_uns;
    logic [DW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    logic            aligned;
    logic [3:0]      lane_mask;
    logic [BW-1:0]   ld_byte;
    logic [HW-1:0]   ld_half;
    logic [DW-1:0]   ld_ext;

    logic            rvalid0_q, rvalid0_d, err0_q, err0_d;
    logic            rvalid1_q, rvalid1_d, err1_q, err1_d;
    logic [DW-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    // Grant: lock state filters eligible ports, then fixed or rotating priority
    always_comb begin
        gnt0_c  = 1'b0;
        gnt1_c  = 1'b0;
        req0_ok = m0_req & (state_q != ST_LOCK1);
        req1_ok = m1_req & (state_q != ST_LOCK0);
        if (rstn) begin
            if (req0_ok && req1_ok) begin
                if (FIXED_PRIO || !prio_q) begin
                    gnt0_c = 1'b1;
                end else begin
                    gnt1_c = 1'b1;
                end
            end else begin
                gnt0_c = req0_ok;
                gnt1_c = req1_ok;
            end
        end
    end

    assign gnt_any = gnt0_c | gnt1_c;

    // Steer the granted port onto the memory side; port 0 when nobody is granted
    always_comb begin
        sel_we    = m0_we;
        sel_size  = m0_size;
        sel_uns   = m0_uns;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        if (gnt1_c) begin
            sel_we    = m1_we;
            sel_size  = m1_size;
            sel_uns   = m1_uns;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end
    end

    // Alignment check and byte-lane mask for the selected access
    always_comb begin
        aligned   = 1'b0;
        lane_mask = 4'b0000;
        case (sel_size)
            SZ_BYTE: begin
                aligned   = 1'b1;
                lane_mask = 4'(4'b0001 << sel_addr[1:0]);
            end
            SZ_HALF: begin
                aligned   = ~sel_addr[0];
                lane_mask = sel_addr[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                aligned   = (sel_addr[1:0] == 2'b00);
                lane_mask = 4'b1111;
            end
            default: begin
                aligned   = 1'b0;
                lane_mask = 4'b0000;
            end
        endcase
    end

    assign mem_we  = gnt_any & sel_we & aligned;
    assign mem_amp = (gnt_any && aligned) ? lane_mask : 4'b0000;
    assign mem_a   = sel_addr;
    assign mem_wd  = sel_wdata;

    // Pick the addressed byte/half out of the read word and extend it
    always_comb begin
        ld_byte = BW'(mem_rd >> {sel_addr[1:0], 3'b000});
        ld_half = sel_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (sel_size)
            SZ_BYTE: ld_ext = sel_uns ? {24'h000000, ld_byte}
                                      : {{24{ld_byte[BW-1]}}, ld_byte};
            SZ_HALF: ld_ext = sel_uns ? {16'h0000, ld_half}
                                      : {{16{ld_half[HW-1]}}, ld_half};
            default: ld_ext = mem_rd;
        endcase
    end

    // Lock FSM next state and round-robin priority update
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt0_c && m0_lock) begin
                    state_d = ST_LOCK0;
                end else if (gnt1_c && m1_lock) begin
                    state_d = ST_LOCK1;
                end
            end
            ST_LOCK0: begin
                if (gnt0_c) begin
                    state_d = m0_lock ? ST_LOCK0 : ST_IDLE;
                end else if (!m0_lock) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK1: begin
                if (gnt1_c) begin
                    state_d = m1_lock ? ST_LOCK1 : ST_IDLE;
                end else if (!m1_lock) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!FIXED_PRIO) begin
            if (gnt0_c) begin
                prio_d = 1'b1;
            end else if (gnt1_c) begin
                prio_d = 1'b0;
            end
        end
    end

    // Lock state and priority registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            prio_q  <= PRIO_RST;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    // Per-port response next state: load data, valid and error pulses
    always_comb begin
        rvalid0_d = gnt0_c & ~sel_we & aligned;
        err0_d    = gnt0_c & ~aligned;
        rdata0_d  = rvalid0_d ? ld_ext : rdata0_q;
        rvalid1_d = gnt1_c & ~sel_we & aligned;
        err1_d    = gnt1_c & ~aligned;
        rdata1_d  = rvalid1_d ? ld_ext : rdata1_q;
    end

    // Response registers; reset drops any pending pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rvalid0_q <= 1'b0;
            err0_q    <= 1'b0;
            rdata0_q  <= '0;
            rvalid1_q <= 1'b0;
            err1_q    <= 1'b0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= rvalid0_d;
            err0_q    <= err0_d;
            rdata0_q  <= rdata0_d;
            rvalid1_q <= rvalid1_d;
            err1_q    <= err1_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign m0_gnt    = gnt0_c;
    assign m1_gnt    = gnt1_c;
    assign m0_rvalid = rvalid0_q;
    assign m0_err    = err0_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rvalid = rvalid1_q;
    assign m1_err    = err1_q;
    assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory, directed accesses, and a
// scoreboard of expected load/error responses popped when the DUT responds.
module tb_dmem_arbiter;

    logic        clk;
    logic        rstn;

    logic        m0_req, m0_we, m0_uns, m0_lock;
    logic [1:0]  m0_size;
    logic [31:0] m0_addr, m0_wdata;
    logic        m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_rdata;

    logic        m1_req, m1_we, m1_uns, m1_lock;
    logic [1:0]  m1_size;
    logic [31:0] m1_addr, m1_wdata;
    logic        m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_rdata;

    logic        mem_we;
    logic [3:0]  mem_amp;
    logic [31:0] mem_a, mem_wd, mem_rd;

    // second instance in fixed-priority mode
    logic        b_req;
    logic        b_m0_gnt, b_m0_rvalid, b_m0_err, b_m1_gnt, b_m1_rvalid, b_m1_err;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic        b_mem_we;
    logic [3:0]  b_mem_amp;
    logic [31:0] b_mem_a, b_mem_wd;
    logic [31:0] b_mem_rd;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        bit          port;
        bit          is_err;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb_q[$];

    logic [31:0] tb_mem [0:63];

    dmem_arbiter #(.FIXED_PRIO(1'b0), .PRIO_RST(1'b0)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_uns(m0_uns),
        .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_uns(m1_uns),
        .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_we(mem_we), .mem_amp(mem_amp), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    dmem_arbiter #(.FIXED_PRIO(1'b1), .PRIO_RST(1'b0)) dut_fixed (
        .clk(clk), .rstn(rstn),
        .m0_req(b_req), .m0_we(1'b0), .m0_size(2'b10), .m0_uns(1'b0),
        .m0_lock(1'b0), .m0_addr(32'h0), .m0_wdata(32'h0),
        .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata), .m0_err(b_m0_err),
        .m1_req(b_req), .m1_we(1'b0), .m1_size(2'b10), .m1_uns(1'b0),
        .m1_lock(1'b0), .m1_addr(32'h4), .m1_wdata(32'h0),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata), .m1_err(b_m1_err),
        .mem_we(b_mem_we), .mem_amp(b_mem_amp), .mem_a(b_mem_a), .mem_wd(b_mem_wd),
        .mem_rd(b_mem_rd)
    );

    assign b_mem_rd = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: combinational read; write takes low bytes of mem_wd into enabled lanes
    assign mem_rd = tb_mem[mem_a[7:2]];
    always @(posedge clk) begin
        if (mem_we) begin
            int lo;
            logic [31:0] sh;
            lo = mem_amp[0] ? 0 : mem_amp[1] ? 1 : mem_amp[2] ? 2 : 3;
            sh = mem_wd << (8 * lo);
            for (int i = 0; i < 4; i++)
                if (mem_amp[i]) tb_mem[mem_a[7:2]][8*i +: 8] <= sh[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input bit p, input bit req, input bit we, input logic [1:0] sz,
                         input bit uns, input bit lk, input logic [31:0] addr,
                         input logic [31:0] wd);
        if (!p) begin
            m0_req = req; m0_we = we; m0_size = sz; m0_uns = uns;
            m0_lock = lk; m0_addr = addr; m0_wdata = wd;
        end else begin
            m1_req = req; m1_we = we; m1_size = sz; m1_uns = uns;
            m1_lock = lk; m1_addr = addr; m1_wdata = wd;
        end
    endtask

    task automatic expect_out(input bit p, input bit e, input logic [31:0] d);
        exp_t x;
        x.port = p; x.is_err = e; x.data = d; x.due = cyc + 1;
        sb_q.push_back(x);
    endtask

    // One access on a single requester: expects a same-cycle grant
    task automatic access(input bit p, input bit we, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] exp_amp, input logic [31:0] exp_rd,
                          input bit exp_err);
        bit g;
        @(negedge clk);
        drive(p, 1'b1, we, sz, uns, 1'b0, addr, wd);
        #1;
        g = p ? m1_gnt : m0_gnt;
        chk("gnt", 32'(g), 32'd1);
        if (g) begin
            chk("mem_amp", 32'(mem_amp), 32'(exp_amp));
            chk("mem_we", 32'(mem_we), 32'(we && !exp_err));
            chk("mem_a", mem_a, addr);
            if (exp_err || !we) expect_out(p, exp_err, exp_rd);
        end
        @(posedge clk);
        #1;
        drive(p, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_rvalid0", 32'(m0_rvalid), 32'd0);
        chk("rst_rvalid1", 32'(m1_rvalid), 32'd0);
        chk("rst_rdata0", m0_rdata, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Scoreboard monitor: every rvalid/err pulse must match the oldest expectation
    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            logic v, e;
            logic [31:0] d;
            exp_t x;
            v = (p == 0) ? m0_rvalid : m1_rvalid;
            e = (p == 0) ? m0_err : m1_err;
            d = (p == 0) ? m0_rdata : m1_rdata;
            if (v || e) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected", {30'h0, v, e}, 32'h0);
                end else begin
                    x = sb_q.pop_front();
                    chk("sb_port", 32'(p), 32'(x.port));
                    chk("sb_err", 32'(e), 32'(x.is_err));
                    chk("sb_rvalid", 32'(v), 32'(!x.is_err));
                    chk("sb_latency", 32'(cyc), 32'(x.due));
                    if (!x.is_err) chk("sb_rdata", d, x.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0;
        b_req = 1'b0;
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 32'h40, 32'h5555AAAA);
        repeat (2) @(negedge clk);
        #1;
        // reset state: no grant or write even with a store request pending
        chk("reset_gnt1", 32'(m1_gnt), 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_rvalid0", 32'(m0_rvalid), 32'd0);
        chk("reset_err1", 32'(m1_err), 32'd0);
        chk("reset_rdata1", m1_rdata, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // word store/load and sub-word extension
        access(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 0);
        access(0, 0, 2'b10, 0, 32'h10, 32'h0, 4'b1111, 32'hDEADBEEF, 0);
        access(1, 1, 2'b10, 0, 32'h20, 32'h80FF7F01, 4'b1111, 32'h0, 0);
        access(0, 0, 2'b00, 0, 32'h23, 32'h0, 4'b1000, 32'hFFFFFF80, 0);
        access(1, 0, 2'b00, 1, 32'h23, 32'h0, 4'b1000, 32'h00000080, 0);
        access(0, 0, 2'b01, 0, 32'h22, 32'h0, 4'b1100, 32'hFFFF80FF, 0);
        access(1, 0, 2'b01, 1, 32'h20, 32'h0, 4'b0011, 32'h00007F01, 0);
        access(0, 1, 2'b01, 0, 32'h30, 32'h00001234, 4'b0011, 32'h0, 0);
        chk("rdata0_hold", m0_rdata, 32'hFFFF80FF);

        // lock: last grant went to port 0, so port 1 holds priority
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 32'h5, 32'h000000AB);
        drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h10, 32'h0);
        #1;
        chk("lock_gnt1", 32'(m1_gnt), 32'd1);
        chk("lock_gnt0", 32'(m0_gnt), 32'd0);
        chk("lock_amp", 32'(mem_amp), 32'h2);
        chk("lock_wd", 32'(mem_wd[7:0]), 32'hAB);
        chk("lock_we", 32'(mem_we), 32'd1);
        @(posedge clk);
        #1;
        m1_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("lock_block0", 32'(m0_gnt), 32'd0);
        end
        @(negedge clk);
        m1_lock = 1'b0;
        #1;
        chk("lock_release_cyc", 32'(m0_gnt), 32'd0);
        @(negedge clk);
        #1;
        chk("lock_after_gnt0", 32'(m0_gnt), 32'd1);
        if (m0_gnt) expect_out(0, 0, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        access(0, 0, 2'b00, 0, 32'h5, 32'h0, 4'b0010, 32'hFFFFFFAB, 0);
        access(1, 0, 2'b00, 1, 32'h5, 32'h0, 4'b0010, 32'h000000AB, 0);

        // misaligned and illegal: granted, no write, error pulse, rdata kept
        access(0, 0, 2'b01, 0, 32'h3, 32'h0, 4'b0000, 32'h0, 1);
        access(0, 1, 2'b10, 0, 32'h2, 32'h11111111, 4'b0000, 32'h0, 1);
        access(1, 0, 2'b11, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 1);
        chk("err_rdata0_hold", m0_rdata, 32'hFFFFFFAB);

        // round-robin from reset priority: 0,1,0,1,... with back-to-back grants
        pulse_reset();
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h10, 32'h0);
        for (int i = 0; i < 6; i++) begin
            bit ep;
            #1;
            ep = (i % 2) == 1;
            chk("rr_gnt0", 32'(m0_gnt), 32'(!ep));
            chk("rr_gnt1", 32'(m1_gnt), 32'(ep));
            expect_out(ep, 0, 32'hDEADBEEF);
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);

        // reset right after a locked load grant: no rvalid, lock released
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h10, 32'h0);
        #1;
        chk("rstA_gnt0", 32'(m0_gnt), 32'd1);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        m0_req = 1'b0;
        drive(1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        #1;
        chk("rstA_rvalid0", 32'(m0_rvalid), 32'd0);
        chk("rstA_gnt1", 32'(m1_gnt), 32'd0);
        chk("rstA_mem_we", 32'(mem_we), 32'd0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        access(1, 0, 2'b10, 0, 32'h10, 32'h0, 4'b1111, 32'hDEADBEEF, 0);
        m0_lock = 1'b0;

        // reset after a port-0 grant (priority moved to 1) restores priority 0
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h10, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        m0_req = 1'b0;
        @(negedge clk);
        #1;
        chk("rstB_rvalid0", 32'(m0_rvalid), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h20, 32'h0);
        #1;
        chk("rstB_prio_gnt0", 32'(m0_gnt), 32'd1);
        chk("rstB_prio_gnt1", 32'(m1_gnt), 32'd0);
        if (m0_gnt) expect_out(0, 0, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);

        // fixed priority: port 0 wins every cycle
        @(negedge clk);
        b_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fixed_gnt0", 32'(b_m0_gnt), 32'd1);
            chk("fixed_gnt1", 32'(b_m1_gnt), 32'd0);
            @(negedge clk);
        end
        b_req = 1'b0;

        repeat (3) @(negedge clk);
        chk("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
